// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings and constants for the IF/DM memory arbiter
package mem_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  typedef logic owner_t;
  localparam owner_t OWNER_IF = 1'b0;
  localparam owner_t OWNER_DM = 1'b1;

  localparam logic [31:0] BUS_ERR_PATTERN = 32'hDEADBEEF;

  // Bits needed to hold 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// rtl/mem_arb_watchdog.sv - loadable down-counter that flags a memory which never acknowledges
module mem_arb_watchdog #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Loaded with TIMEOUT-1, so zero is reached on the TIMEOUT-th enabled cycle.
  assign expired_o = en_i && (count_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between fetch and data access, DM-first with
// bounded IF starvation and a watchdog against a memory that never acknowledges.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MAX_DM_STREAK = 3,
  parameter int unsigned TIMEOUT       = 15
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_ready_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  dm_req_i,
  input  logic                  dm_we_i,
  input  logic [ADDR_WIDTH-1:0] dm_addr_i,
  input  logic [DATA_WIDTH-1:0] dm_wdata_i,
  output logic                  dm_ready_o,
  output logic [DATA_WIDTH-1:0] dm_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  bus_err_o
);

  localparam int unsigned STREAK_W = cnt_width(MAX_DM_STREAK);
  localparam int unsigned WD_W     = cnt_width(TIMEOUT);
  localparam logic [STREAK_W-1:0]   STREAK_MAX = STREAK_W'(MAX_DM_STREAK);
  localparam logic [WD_W-1:0]       WD_LOAD    = WD_W'(TIMEOUT - 1);
  localparam logic [DATA_WIDTH-1:0] ERR_WORD   = DATA_WIDTH'(BUS_ERR_PATTERN);

  logic [1:0]            state_q, state_d;
  owner_t                owner_q, owner_d;
  logic [STREAK_W-1:0]   streak_q, streak_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  if_ready_q, if_ready_d;
  logic                  dm_ready_q, dm_ready_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
  logic                  bus_err_q, bus_err_d;

  logic dm_win;
  logic wd_load;
  logic wd_en;
  logic wd_clear;
  logic wd_expired;

  mem_arb_watchdog #(
    .WIDTH (WD_W)
  ) u_watchdog (
    .clk_i      (clock_i),
    .rst_i      (reset_i),
    .clear_i    (wd_clear),
    .load_i     (wd_load),
    .load_val_i (WD_LOAD),
    .en_i       (wd_en),
    .expired_o  (wd_expired)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    bus_err_d   = bus_err_q;
    dm_win      = 1'b0;
    wd_load     = 1'b0;
    wd_en       = 1'b0;
    wd_clear    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // IF is forced through once DM has won MAX_DM_STREAK times in a row over it.
        dm_win = dm_req_i && !(if_req_i && (streak_q == STREAK_MAX));
        if (dm_win) begin
          owner_d     = OWNER_DM;
          mem_we_d    = dm_we_i;
          mem_addr_d  = dm_addr_i;
          mem_wdata_d = dm_wdata_i;
          mem_req_d   = 1'b1;
          wd_load     = 1'b1;
          state_d     = ST_ISSUE;
          if (!if_req_i) begin
            streak_d = '0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + STREAK_W'(1);
          end
        end else if (if_req_i) begin
          owner_d     = OWNER_IF;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr_i;
          mem_wdata_d = '0;
          mem_req_d   = 1'b1;
          wd_load     = 1'b1;
          state_d     = ST_ISSUE;
          streak_d    = '0;
        end
      end

      ST_ISSUE: begin
        wd_en = 1'b1;
        // Ack is checked first so an ack on the final watchdog cycle still succeeds.
        if (mem_ack_i) begin
          if (owner_q == OWNER_DM) begin
            dm_rdata_d = mem_we_q ? '0 : mem_rdata_i;
            dm_ready_d = 1'b1;
          end else begin
            if_rdata_d = mem_rdata_i;
            if_ready_d = 1'b1;
          end
          mem_req_d = 1'b0;
          wd_clear  = 1'b1;
          state_d   = ST_RESP;
        end else if (wd_expired) begin
          if (owner_q == OWNER_DM) begin
            dm_rdata_d = ERR_WORD;
            dm_ready_d = 1'b1;
          end else begin
            if_rdata_d = ERR_WORD;
            if_ready_d = 1'b1;
          end
          bus_err_d = 1'b1;
          mem_req_d = 1'b0;
          wd_clear  = 1'b1;
          state_d   = ST_RESP;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWNER_IF;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign if_ready_o  = if_ready_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_ready_o  = dm_ready_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign bus_err_o   = bus_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter against a behavioural model
module tb_mem_arbiter;

  localparam int MAXS = 3;
  localparam int TMO  = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, if_req, dm_req, dm_we, mem_ack;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic        if_ready, dm_ready, mem_req, mem_we, bus_err;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] dev_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int mem_cnt  = 0;
  int cur_wait = 0;
  bit rand_waits = 1'b0;
  bit mem_never  = 1'b0;
  bit ack_force  = 1'b0;

  mem_arbiter #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .MAX_DM_STREAK (MAXS),
    .TIMEOUT       (TMO)
  ) dut (
    .clock_i     (clk),
    .reset_i     (reset),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_ready_o  (if_ready),
    .if_rdata_o  (if_rdata),
    .dm_req_i    (dm_req),
    .dm_we_i     (dm_we),
    .dm_addr_i   (dm_addr),
    .dm_wdata_i  (dm_wdata),
    .dm_ready_o  (dm_ready),
    .dm_rdata_o  (dm_rdata),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_ack_i   (mem_ack),
    .mem_rdata_i (mem_rdata),
    .bus_err_o   (bus_err)
  );

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5EED_0000;
  endfunction

  function automatic logic [31:0] dev_rd(input logic [31:0] a);
    if (dev_mem.exists(a)) return dev_mem[a];
    return dflt(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return dflt(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock; the memory model then answers mem_req after cur_wait wait states.
  task automatic tick();
    @(posedge clk);
    #1;
    if (ack_force) begin
      mem_ack   = 1'b1;
      mem_rdata = 32'hBAD0BAD0;
    end else if (mem_req) begin
      if (mem_cnt == 0 && rand_waits) cur_wait = int'($urandom_range(0, 3));
      if (!mem_never && mem_cnt == cur_wait) begin
        mem_ack   = 1'b1;
        mem_rdata = dev_rd(mem_addr);
        if (mem_we) dev_mem[mem_addr] = mem_wdata;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
      end
      mem_cnt++;
    end else begin
      mem_ack   = 1'b0;
      mem_cnt   = 0;
      mem_rdata = $urandom;
    end
  endtask

  task automatic wait_ready(input int maxc, output int cyc);
    cyc = -1;
    for (int i = 1; i <= maxc; i++) begin
      tick();
      if (if_ready || dm_ready) begin
        cyc = i;
        return;
      end
    end
  endtask

  initial begin
    int   cyc;
    int   n;
    int   pulses;
    int   issued;
    int   done;
    logic [7:0]  order;
    logic [31:0] if_exp, dm_exp;
    logic req_prev, starve, exp_dm;
    bit   hist[$];

    reset = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    tick();
    tick();
    chk("rst_if_ready", 32'(if_ready), 0);
    chk("rst_dm_ready", 32'(dm_ready), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_bus_err", 32'(bus_err), 0);
    reset = 1'b0;

    // IF-only fetch, zero-wait memory
    dev_mem[32'h40] = 32'h8C220004;
    cur_wait = 0;
    if_addr = 32'h40; if_req = 1'b1;
    tick();
    chk("if_mem_req_n1", 32'(mem_req), 1);
    chk("if_mem_addr", mem_addr, 32'h40);
    chk("if_mem_we", 32'(mem_we), 0);
    tick();
    chk("if_ready_n2", 32'(if_ready), 1);
    chk("if_rdata", if_rdata, 32'h8C220004);
    chk("if_dm_ready_quiet", 32'(dm_ready), 0);
    if_req = 1'b0;
    tick();
    chk("if_ready_one_cycle", 32'(if_ready), 0);
    chk("if_mem_req_dropped", 32'(mem_req), 0);

    // Store then load at 0x100, load with 2 wait states
    dm_addr = 32'h100; dm_we = 1'b1; dm_wdata = 32'hCAFEF00D; dm_req = 1'b1;
    tick();
    chk("st_mem_req", 32'(mem_req), 1);
    chk("st_mem_we", 32'(mem_we), 1);
    chk("st_mem_wdata", mem_wdata, 32'hCAFEF00D);
    tick();
    chk("st_dm_ready", 32'(dm_ready), 1);
    chk("st_dm_rdata", dm_rdata, 0);
    chk("st_if_ready_quiet", 32'(if_ready), 0);
    dm_req = 1'b0; dm_we = 1'b0; dm_wdata = '0;
    tick();
    cur_wait = 2;
    dm_req = 1'b1;
    wait_ready(12, cyc);
    chk("ld_latency", cyc, 4);
    chk("ld_dm_ready", 32'(dm_ready), 1);
    chk("ld_dm_rdata", dm_rdata, 32'hCAFEF00D);
    dm_req = 1'b0;
    tick();

    // Continuous contention
    cur_wait = 0;
    if_addr = 32'h200; dm_addr = 32'h104; dm_we = 1'b0;
    if_req = 1'b1; dm_req = 1'b1;
    order = '0; n = 0;
    for (int i = 0; i < 200 && n < 8; i++) begin
      tick();
      if (dm_ready) begin order[n] = 1'b1; n++; end
      else if (if_ready) begin order[n] = 1'b0; n++; end
    end
    chk("cont_count", n, 8);
    chk("cont_order", 32'(order), 32'h77);
    if_req = 1'b0; dm_req = 1'b0;
    tick();

    // Randomized traffic against a history-based arbitration model
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ref_mem = dev_mem;
    rand_waits = 1'b1;
    hist.delete();
    issued = 0; done = 0; req_prev = 1'b0;
    if_exp = '0; dm_exp = '0;
    for (int c = 0; c < 4000 && !(issued >= 40 && !if_req && !dm_req); c++) begin
      tick();
      if (mem_req && !req_prev) begin
        starve = if_req && (hist.size() >= MAXS);
        if (starve) begin
          for (int k = 1; k <= MAXS; k++) if (!hist[hist.size() - k]) starve = 1'b0;
        end
        exp_dm = dm_req && !starve;
        chk("rnd_grant_addr", mem_addr, exp_dm ? dm_addr : if_addr);
        chk("rnd_grant_we", 32'(mem_we), 32'(exp_dm ? dm_we : 1'b0));
        chk("rnd_grant_wdata", mem_wdata, exp_dm ? dm_wdata : 32'h0);
        hist.push_back(exp_dm && if_req);
      end
      req_prev = mem_req;
      if (if_ready || dm_ready) chk("rnd_ready_excl", 32'(if_ready & dm_ready), 0);
      if (if_ready) begin
        chk("rnd_if_rdata", if_rdata, if_exp);
        if_req = 1'b0; done++;
      end
      if (dm_ready) begin
        chk("rnd_dm_rdata", dm_rdata, dm_exp);
        dm_req = 1'b0; done++;
      end
      if (!if_req && issued < 40 && $urandom_range(0, 2) != 0) begin
        if_addr = 32'h200 + 32'(4 * $urandom_range(0, 15));
        if_exp  = ref_rd(if_addr);
        if_req  = 1'b1; issued++;
      end
      if (!dm_req && issued < 40 && $urandom_range(0, 2) != 0) begin
        dm_addr  = 32'h100 + 32'(4 * $urandom_range(0, 7));
        dm_we    = 1'($urandom_range(0, 1));
        dm_wdata = $urandom;
        if (dm_we) begin
          dm_exp = '0;
          ref_mem[dm_addr] = dm_wdata;
        end else begin
          dm_exp = ref_rd(dm_addr);
        end
        dm_req = 1'b1; issued++;
      end
    end
    chk("rnd_all_done", done, issued);
    chk("rnd_drained", 32'(if_req | dm_req), 0);
    rand_waits = 1'b0;
    tick();

    // Timeout: memory never acknowledges
    mem_never = 1'b1;
    dm_addr = 32'h108; dm_we = 1'b0; dm_req = 1'b1;
    wait_ready(40, cyc);
    chk("to_latency", cyc, 16);
    chk("to_dm_ready", 32'(dm_ready), 1);
    chk("to_dm_rdata", dm_rdata, 32'hDEADBEEF);
    chk("to_bus_err", 32'(bus_err), 1);
    chk("to_mem_req_dropped", 32'(mem_req), 0);
    dm_req = 1'b0; mem_never = 1'b0;
    tick();
    cur_wait = 1;
    if_addr = 32'h40; if_req = 1'b1;
    wait_ready(12, cyc);
    chk("post_err_latency", cyc, 3);
    chk("post_err_if_rdata", if_rdata, 32'h8C220004);
    chk("bus_err_sticky", 32'(bus_err), 1);
    if_req = 1'b0;
    tick();

    // Reset during the second wait cycle of an ISSUE
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("bus_err_cleared", 32'(bus_err), 0);
    cur_wait = 10;
    dm_addr = 32'h10C; dm_req = 1'b1;
    tick();
    tick();
    reset = 1'b1; dm_req = 1'b0;
    tick();
    chk("rst_mid_mem_req", 32'(mem_req), 0);
    chk("rst_mid_dm_ready", 32'(dm_ready), 0);
    reset = 1'b0;
    ack_force = 1'b1;
    tick();
    ack_force = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      pulses += int'(if_ready) + int'(dm_ready) + int'(mem_req);
    end
    chk("late_ack_ignored", pulses, 0);
    cur_wait = 0;
    if_addr = 32'h40; if_req = 1'b1;
    wait_ready(12, cyc);
    chk("fresh_if_latency", cyc, 2);
    chk("fresh_if_rdata", if_rdata, 32'h8C220004);
    if_req = 1'b0;
    tick();

    // Ack on the very cycle the watchdog would expire
    cur_wait = TMO - 1;
    if_addr = 32'h44; if_req = 1'b1;
    wait_ready(40, cyc);
    chk("race_latency", cyc, 16);
    chk("race_if_rdata", if_rdata, dflt(32'h44));
    chk("race_bus_err", 32'(bus_err), 0);
    if_req = 1'b0;
    cur_wait = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the CPU's single memory port between two requesters: instruction fetch (IF) and data access (DM, load/store).
- Sits between the datapath and the memory.
- Serialises transactions through a small FSM.
- Gives DM priority, with a bounded-starvation guarantee for IF.
- Watchdog flags a memory that never acknowledges.

Parameters:
- ADDR_WIDTH, 32, address width of requesters and memory.
- DATA_WIDTH, 32, data word width.
- MAX_DM_STREAK, 3, max consecutive DM grants while IF waits (≥1).
- TIMEOUT, 15, cycles waiting for mem_ack before abort (≥1).

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  ADDR_WIDTH  fetch address.
- if_ready  out  1  one-cycle completion pulse to fetch.
- if_rdata  out  DATA_WIDTH  fetched word, valid while if_ready.
- dm_req  in  1  data request; held until dm_ready.
- dm_we  in  1  1=store, 0=load.
- dm_addr  in  ADDR_WIDTH  data address.
- dm_wdata  in  DATA_WIDTH  store data.
- dm_ready  out  1  one-cycle completion pulse to data stage.
- dm_rdata  out  DATA_WIDTH  load word, valid while dm_ready; 0 for stores.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_ack  in  1  memory completion; may assert in the first mem_req cycle.
- mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack.
- bus_err  out  1  sticky timeout flag.

Behaviour:
- Reset values:
  - state=IDLE.
  - All outputs 0: if_ready, dm_ready, mem_req, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata, bus_err.
  - Streak counter 0, watchdog 0.
- State IDLE: arbitrate on sampled requests.
  - DM wins when dm_req && !(if_req && streak==MAX_DM_STREAK).
  - Otherwise IF wins if if_req.
  - The winner's addr/we/wdata are latched into mem_* registers (IF: we=0, wdata=0). Owner is recorded. Next state ISSUE.
- Streak counter:
  - Increments on a DM grant while if_req=1.
  - Clears on any IF grant, or on a DM grant with if_req=0.
  - Saturates at MAX_DM_STREAK.
- State ISSUE:
  - mem_req=1; mem_* stable; watchdog counts cycles.
  - On mem_ack: mem_rdata is registered into the owner's rdata (0 for store); mem_req drops at the same edge; next state RESP.
  - If the watchdog reaches TIMEOUT without mem_ack: bus_err set (sticky until reset); owner rdata=32'hDEADBEEF; next state RESP.
- State RESP:
  - Owner's ready=1 for exactly one cycle; the other ready stays 0. Next state IDLE.
  - Requests are not sampled in RESP.
  - A req still high in the following IDLE cycle is a new transaction.
- Latency: request sampled in IDLE at cycle N → mem_req at N+1 → with zero-wait ack at N+1, ready at N+2. Each extra memory wait state adds one cycle.
- Requester inputs are ignored after the grant, because mem_* are latched.
- Simultaneous events:
  - Both requests in IDLE: the rule above applies.
  - mem_ack in the same cycle the watchdog hits TIMEOUT: ack wins, no error.
  - mem_ack in IDLE or RESP is ignored.
- Reset mid-transaction: at the reset edge, state→IDLE and mem_req→0. No ready pulse is produced for the aborted transaction. A late mem_ack is ignored.
- rdata registers hold their value between responses. They are only defined while ready is high.

Decomposition:
- Shared constants header (the team's existing constants include):
  - state encodings IDLE/ISSUE/RESP.
  - owner encoding OWNER_IF/OWNER_DM.
  - bus error pattern 32'hDEADBEEF.
- One natural sub-module: mem_arb_watchdog, a loadable down-counter with clear/enable and an expired output. The FSM, streak counter and output registers stay in mem_arbiter.

Test Plan:
- IF-only load: if_req=1, if_addr=0x40, memory acks in first cycle with 0x8C220004 → mem_req at N+1, if_ready pulse at N+2 with if_rdata=0x8C220004. dm_ready stays 0.
- Store then load to 0x100: dm_we=1, dm_wdata=0xCAFEF00D → mem_we=1, mem_wdata=0xCAFEF00D, dm_rdata=0. The following load returns 0xCAFEF00D from the memory model with 2 wait states; dm_ready 4 cycles after the request.
- Contention, MAX_DM_STREAK=3: dm_req and if_req held high continuously → grant order DM,DM,DM,IF,DM,DM,DM,IF; IF never waits more than 3 transactions.
- Timeout: memory never acks, TIMEOUT=15 → dm_ready after 15 ISSUE cycles with dm_rdata=0xDEADBEEF. bus_err=1 and remains 1 across later successful transactions until reset.
- Reset mid-ISSUE: reset asserted on the 2nd wait cycle → next edge mem_req=0, state IDLE, no ready pulse. A late mem_ack is ignored. A fresh if_req afterwards completes normally.
- Ack/timeout race: mem_ack arrives exactly on watchdog cycle 15 → normal data returned, bus_err stays 0.
